// File: rtl/scoreboard_hazard_unit.sv
// Issue-stage hazard unit. A per-register countdown tracks pending writebacks,
// so ID stalls until every source it reads has drained.
module scoreboard_hazard_unit #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 2,
  parameter int NOFWD_LAT  = 2,
  parameter int LOAD_LAT   = 1,
  parameter int PERF_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [REG_ADDR_W-1:0]      src1,
  input  logic [REG_ADDR_W-1:0]      src2,
  input  logic                       has_two_src,
  input  logic [REG_ADDR_W-1:0]      dest,
  input  logic                       wb_enable,
  input  logic                       is_load,
  input  logic                       fwd_en,
  input  logic                       flush,
  input  logic                       freeze,
  output logic                       hazard_detected,
  output logic                       src1_ready,
  output logic                       src2_ready,
  output logic [(2**REG_ADDR_W)-1:0] pending_mask,
  output logic [PERF_W-1:0]          stall_count
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int MAX_LAT  = (NOFWD_LAT > LOAD_LAT) ? NOFWD_LAT : LOAD_LAT;

  if ((2 ** CNT_W) - 1 < MAX_LAT) begin : g_cnt_w_check
    $error("scoreboard_hazard_unit: CNT_W too narrow for the configured latencies");
  end

  logic [CNT_W-1:0]  cnt_q [NUM_REGS];
  logic [CNT_W-1:0]  cnt_d [NUM_REGS];
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] stall_d;
  logic              accept;
  logic              mark;
  logic [CNT_W-1:0]  set_lat;

  // Readiness uses pre-issue state, so an instruction never blocks on its own dest.
  assign src1_ready      = (cnt_q[src1] == '0);
  assign src2_ready      = !has_two_src || (cnt_q[src2] == '0);
  assign hazard_detected = issue_valid && !flush && !(src1_ready && src2_ready);
  assign accept          = issue_valid && !flush && !freeze && !hazard_detected;
  assign mark            = accept && wb_enable && (!fwd_en || is_load);
  assign set_lat         = fwd_en ? CNT_W'(LOAD_LAT) : CNT_W'(NOFWD_LAT);
  assign stall_count     = stall_q;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pending_mask[r] = (cnt_q[r] != '0);
    end
  end

  // A fresh set overrides the decrement on the same register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!freeze && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
    if (mark) begin
      cnt_d[dest] = set_lat;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (hazard_detected && !freeze && (stall_q != '1)) begin
      stall_d = stall_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      stall_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: directed scenarios plus random traffic,
// checked against a ready-time model kept in active (unfrozen) cycles.
module tb_scoreboard_hazard_unit;

  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;
  localparam int CNT_W      = 2;
  localparam int NOFWD_LAT  = 2;
  localparam int LOAD_LAT   = 1;
  // Narrow counter so saturation is reachable in a few hundred cycles.
  localparam int PERF_W     = 8;
  localparam int STALL_MAX  = (1 << PERF_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  issueValid;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  hasTwoSrc;
  logic [REG_ADDR_W-1:0] dest;
  logic                  wbEnable;
  logic                  isLoad;
  logic                  fwdEn;
  logic                  flush;
  logic                  freeze;
  logic                  hazardDetected;
  logic                  src1Ready;
  logic                  src2Ready;
  logic [NUM_REGS-1:0]   pendingMask;
  logic [PERF_W-1:0]     stallCount;

  int errors = 0;
  int checks = 0;

  int activeCycle;
  int readyAt [NUM_REGS];
  int stallModel;

  scoreboard_hazard_unit #(
    .REG_ADDR_W(REG_ADDR_W),
    .CNT_W     (CNT_W),
    .NOFWD_LAT (NOFWD_LAT),
    .LOAD_LAT  (LOAD_LAT),
    .PERF_W    (PERF_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issueValid),
    .src1           (src1),
    .src2           (src2),
    .has_two_src    (hasTwoSrc),
    .dest           (dest),
    .wb_enable      (wbEnable),
    .is_load        (isLoad),
    .fwd_en         (fwdEn),
    .flush          (flush),
    .freeze         (freeze),
    .hazard_detected(hazardDetected),
    .src1_ready     (src1Ready),
    .src2_ready     (src2Ready),
    .pending_mask   (pendingMask),
    .stall_count    (stallCount)
  );

  function automatic bit modelPend(input logic [REG_ADDR_W-1:0] r);
    return activeCycle < readyAt[r];
  endfunction

  function automatic logic [NUM_REGS-1:0] modelMask();
    logic [NUM_REGS-1:0] m;
    for (int i = 0; i < NUM_REGS; i++) m[i] = activeCycle < readyAt[i];
    return m;
  endfunction

  function automatic bit modelHazard();
    return issueValid && !flush && (modelPend(src1) || (hasTwoSrc && modelPend(src2)));
  endfunction

  task automatic modelReset();
    activeCycle = 0;
    stallModel  = 0;
    for (int i = 0; i < NUM_REGS; i++) readyAt[i] = 0;
  endtask

  // A register written at active cycle n is readable from cycle n+1+latency.
  task automatic tick();
    bit haz, acc, mrk;
    int lat;
    haz = modelHazard();
    acc = issueValid && !flush && !freeze && !haz;
    mrk = acc && wbEnable && (!fwdEn || isLoad);
    lat = fwdEn ? LOAD_LAT : NOFWD_LAT;
    @(posedge clk);
    if (!freeze) begin
      if (haz && stallModel < STALL_MAX) stallModel++;
      if (mrk) readyAt[dest] = activeCycle + 1 + lat;
      activeCycle++;
    end
    #1;
  endtask

  task automatic setIdle();
    issueValid = 0; src1 = 0; src2 = 0; hasTwoSrc = 0; dest = 0;
    wbEnable = 0; isLoad = 0; fwdEn = 0; flush = 0; freeze = 0;
  endtask

  task automatic drain();
    setIdle();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 0;
    setIdle();
    modelReset();
    #1;
    checks++; if (pendingMask !== '0) begin errors++; $display("[TB] FAIL reset_mask: got %h expected 0", pendingMask); end
    checks++; if (hazardDetected !== 1'b0) begin errors++; $display("[TB] FAIL reset_hazard: got %b expected 0", hazardDetected); end
    checks++; if (stallCount !== '0) begin errors++; $display("[TB] FAIL reset_stall: got %0d expected 0", stallCount); end
    checks++; if (src1Ready !== 1'b1 || src2Ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b%b expected 11", src1Ready, src2Ready); end
    @(negedge clk);
    rst = 1;
    tick();
    issueValid = 1; src1 = 3;
    #1;
    checks++; if (hazardDetected !== 1'b0) begin errors++; $display("[TB] FAIL idle_hazard: got %b expected 0", hazardDetected); end
    checks++; if (pendingMask !== '0) begin errors++; $display("[TB] FAIL idle_mask: got %h expected 0", pendingMask); end
    tick();
  endtask

  task automatic test_nofwd_raw();
    int sc0;
    bit exp;
    drain();
    sc0 = stallModel;
    issueValid = 1; wbEnable = 1; dest = 2; src1 = 0; fwdEn = 0;
    #1;
    checks++; if (hazardDetected !== 1'b0) begin errors++; $display("[TB] FAIL nofwd_producer: got %b expected 0", hazardDetected); end
    tick();
    wbEnable = 0; src1 = 2;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp = (i < 2);
      checks++; if (hazardDetected !== exp) begin errors++; $display("[TB] FAIL nofwd_hazard[%0d]: got %b expected %b", i, hazardDetected, exp); end
      checks++; if (pendingMask[2] !== exp) begin errors++; $display("[TB] FAIL nofwd_mask2[%0d]: got %b expected %b", i, pendingMask[2], exp); end
      tick();
    end
    checks++; if (stallCount !== PERF_W'(sc0 + 2)) begin errors++; $display("[TB] FAIL nofwd_stalls: got %0d expected %0d", stallCount, sc0 + 2); end
  endtask

  task automatic test_fwd();
    drain();
    fwdEn = 1; issueValid = 1; wbEnable = 1; isLoad = 0; dest = 4; src1 = 0;
    tick();
    wbEnable = 0; src1 = 4;
    #1;
    checks++; if (hazardDetected !== 1'b0) begin errors++; $display("[TB] FAIL fwd_alu_hazard: got %b expected 0", hazardDetected); end
    checks++; if (pendingMask[4] !== 1'b0) begin errors++; $display("[TB] FAIL fwd_alu_mask: got %b expected 0", pendingMask[4]); end
    tick();
    wbEnable = 1; isLoad = 1; dest = 4; src1 = 0;
    tick();
    wbEnable = 0; isLoad = 0; src2 = 4; hasTwoSrc = 1;
    #1;
    checks++; if (hazardDetected !== 1'b1) begin errors++; $display("[TB] FAIL fwd_load_hazard: got %b expected 1", hazardDetected); end
    checks++; if (src2Ready !== 1'b0) begin errors++; $display("[TB] FAIL fwd_load_src2: got %b expected 0", src2Ready); end
    tick();
    checks++; if (hazardDetected !== 1'b0) begin errors++; $display("[TB] FAIL fwd_load_release: got %b expected 0", hazardDetected); end
    tick();
    wbEnable = 1; isLoad = 1; dest = 4; hasTwoSrc = 0; src2 = 0;
    tick();
    wbEnable = 0; isLoad = 0; src2 = 4; hasTwoSrc = 0;
    #1;
    checks++; if (hazardDetected !== 1'b0) begin errors++; $display("[TB] FAIL fwd_one_src_hazard: got %b expected 0", hazardDetected); end
    checks++; if (src2Ready !== 1'b1) begin errors++; $display("[TB] FAIL fwd_one_src_ready: got %b expected 1", src2Ready); end
    tick();
  endtask

  task automatic test_freeze();
    int sc0;
    drain();
    fwdEn = 1; issueValid = 1; wbEnable = 1; isLoad = 1; dest = 5;
    tick();
    wbEnable = 0; isLoad = 0; src1 = 5; freeze = 1;
    sc0 = stallModel;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (hazardDetected !== 1'b1) begin errors++; $display("[TB] FAIL freeze_hazard[%0d]: got %b expected 1", i, hazardDetected); end
      checks++; if (pendingMask[5] !== 1'b1) begin errors++; $display("[TB] FAIL freeze_mask5[%0d]: got %b expected 1", i, pendingMask[5]); end
      checks++; if (stallCount !== PERF_W'(sc0)) begin errors++; $display("[TB] FAIL freeze_stall[%0d]: got %0d expected %0d", i, stallCount, sc0); end
      tick();
    end
    freeze = 0;
    #1;
    checks++; if (hazardDetected !== 1'b1) begin errors++; $display("[TB] FAIL unfreeze_hazard: got %b expected 1", hazardDetected); end
    tick();
    checks++; if (hazardDetected !== 1'b0) begin errors++; $display("[TB] FAIL unfreeze_accept: got %b expected 0", hazardDetected); end
    checks++; if (stallCount !== PERF_W'(sc0 + 1)) begin errors++; $display("[TB] FAIL unfreeze_stall: got %0d expected %0d", stallCount, sc0 + 1); end
    tick();
  endtask

  task automatic test_flush();
    int sc0;
    drain();
    issueValid = 1; wbEnable = 1; dest = 6; flush = 1;
    #1;
    checks++; if (hazardDetected !== 1'b0) begin errors++; $display("[TB] FAIL flush_hazard: got %b expected 0", hazardDetected); end
    tick();
    flush = 0; issueValid = 0; wbEnable = 0;
    #1;
    checks++; if (pendingMask[6] !== 1'b0) begin errors++; $display("[TB] FAIL flush_mask6: got %b expected 0", pendingMask[6]); end
    issueValid = 1; wbEnable = 1;
    tick();
    wbEnable = 0; src1 = 6; flush = 1;
    sc0 = stallModel;
    #1;
    checks++; if (hazardDetected !== 1'b0) begin errors++; $display("[TB] FAIL flush_pending_hazard: got %b expected 0", hazardDetected); end
    tick();
    checks++; if (stallCount !== PERF_W'(sc0)) begin errors++; $display("[TB] FAIL flush_stall: got %0d expected %0d", stallCount, sc0); end
    checks++; if (pendingMask !== modelMask()) begin errors++; $display("[TB] FAIL flush_decrement: got %h expected %h", pendingMask, modelMask()); end
  endtask

  task automatic test_random();
    drain();
    for (int i = 0; i < 400; i++) begin
      issueValid = ($urandom_range(0, 3) != 0);
      src1       = REG_ADDR_W'($urandom_range(0, 5));
      src2       = REG_ADDR_W'($urandom_range(0, 5));
      dest       = REG_ADDR_W'($urandom_range(0, 5));
      hasTwoSrc  = 1'($urandom_range(0, 1));
      wbEnable   = ($urandom_range(0, 3) != 0);
      isLoad     = 1'($urandom_range(0, 1));
      fwdEn      = 1'($urandom_range(0, 1));
      flush      = ($urandom_range(0, 7) == 0);
      freeze     = ($urandom_range(0, 7) == 0);
      #1;
      checks++; if (hazardDetected !== modelHazard()) begin errors++; $display("[TB] FAIL rand_hazard[%0d]: got %b expected %b", i, hazardDetected, modelHazard()); end
      checks++; if (src1Ready !== !modelPend(src1)) begin errors++; $display("[TB] FAIL rand_src1[%0d]: got %b expected %b", i, src1Ready, !modelPend(src1)); end
      checks++; if (src2Ready !== (!hasTwoSrc || !modelPend(src2))) begin errors++; $display("[TB] FAIL rand_src2[%0d]: got %b expected %b", i, src2Ready, (!hasTwoSrc || !modelPend(src2))); end
      checks++; if (pendingMask !== modelMask()) begin errors++; $display("[TB] FAIL rand_mask[%0d]: got %h expected %h", i, pendingMask, modelMask()); end
      checks++; if (stallCount !== PERF_W'(stallModel)) begin errors++; $display("[TB] FAIL rand_stall[%0d]: got %0d expected %0d", i, stallCount, stallModel); end
      tick();
    end
  endtask

  task automatic test_saturation();
    drain();
    for (int i = 0; i < 200; i++) begin
      issueValid = 1; wbEnable = 1; dest = 1; src1 = 0; fwdEn = 0;
      tick();
      wbEnable = 0; src1 = 1;
      tick();
      tick();
      checks++; if (stallCount !== PERF_W'(stallModel)) begin errors++; $display("[TB] FAIL sat_track[%0d]: got %0d expected %0d", i, stallCount, stallModel); end
    end
    checks++; if (stallCount !== PERF_W'(STALL_MAX)) begin errors++; $display("[TB] FAIL sat_hold: got %0d expected %0d", stallCount, STALL_MAX); end
    setIdle();
  endtask

  task automatic test_reset_midflight();
    drain();
    issueValid = 1; wbEnable = 1; dest = 7; fwdEn = 0;
    tick();
    issueValid = 0; wbEnable = 0;
    rst = 0;
    modelReset();
    #1;
    checks++; if (pendingMask !== '0) begin errors++; $display("[TB] FAIL midrst_mask: got %h expected 0", pendingMask); end
    checks++; if (stallCount !== '0) begin errors++; $display("[TB] FAIL midrst_stall: got %0d expected 0", stallCount); end
    @(negedge clk);
    rst = 1;
    tick();
    issueValid = 1; src1 = 7;
    #1;
    checks++; if (hazardDetected !== 1'b0) begin errors++; $display("[TB] FAIL midrst_hazard: got %b expected 0", hazardDetected); end
    tick();
  endtask

  initial begin
    test_reset();
    test_nofwd_raw();
    test_fwd();
    test_freeze();
    test_flush();
    test_random();
    test_saturation();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
- Parametrised, stateful successor to the combinational EX/MEM hazard check; sits beside the ID stage and decides whether the decoding instruction may issue.
- Keeps a per-register countdown scoreboard of pending writebacks instead of comparing against fixed stage destinations.
- Supports a runtime forwarding mode with a distinct load-use latency, a pipeline freeze, ID-stage flush, and a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 4, register address width; NUM_REGS = 2**REG_ADDR_W.
- CNT_W, 2, per-register countdown width; must hold max(NOFWD_LAT, LOAD_LAT).
- NOFWD_LAT, 2, cycles a dependent instruction waits when forwarding is off (producer through EX and MEM).
- LOAD_LAT, 1, cycles a dependent instruction waits after a load when forwarding is on.
- PERF_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  ID holds a valid instruction.
- src1  in  REG_ADDR_W  first source register (Rn).
- src2  in  REG_ADDR_W  second source register (Rm).
- has_two_src  in  1  src2 is a real operand.
- dest  in  REG_ADDR_W  destination register of the ID instruction.
- wb_enable  in  1  ID instruction writes dest.
- is_load  in  1  ID instruction is a memory load.
- fwd_en  in  1  forwarding mode select, sampled at issue.
- flush  in  1  ID instruction is being killed (branch taken).
- freeze  in  1  whole pipeline held (memory wait).
- hazard_detected  out  1  stall ID this cycle.
- src1_ready  out  1  cnt[src1] == 0.
- src2_ready  out  1  !has_two_src or cnt[src2] == 0.
- pending_mask  out  NUM_REGS  bit r set when cnt[r] != 0.
- stall_count  out  PERF_W  saturating count of stall cycles.

Behaviour:
- State: cnt[0..NUM_REGS-1], each CNT_W bits, plus stall_count.
- Reset (rst low, asynchronous): all cnt = 0 and stall_count = 0. Therefore pending_mask = 0, src1_ready = 1, src2_ready = 1, and hazard_detected = 0.
- hazard_detected (combinational) = issue_valid & !flush & (!src1_ready | !src2_ready). It is 0 whenever issue_valid = 0 or flush = 1.
- accept = issue_valid & !flush & !freeze & !hazard_detected.
- mark = accept & wb_enable & (!fwd_en | is_load).
- Set latency L = fwd_en ? LOAD_LAT : NOFWD_LAT. ALU results with fwd_en = 1 set no scoreboard entry (zero wait).
- Each edge with freeze = 0:
  - every nonzero cnt decrements by 1;
  - then, if mark, cnt[dest] <= L. Set overrides decrement on the same register.
- Each edge with freeze = 1: all cnt hold, no set, stall_count holds.
- Timing with fwd_en = 0: producer accepted at edge t. A consumer of dest stalls in cycles t+1 and t+2 and issues in cycle t+3. This is equivalent to the old EX/MEM compare.
- Timing with fwd_en = 1, load: consumer stalls exactly 1 cycle.
- Producer reading its own dest (e.g. r1 = r1 + x): the check uses pre-issue state, so it is not self-blocking.
- A write-after-write to a register with nonzero cnt reloads cnt to L.
- fwd_en changing mid-flight: existing counts run down unchanged; the new mode applies only to newly accepted instructions.
- flush: the ID instruction is not accepted and sets nothing; counters keep decrementing; no stall is counted.
- stall_count: increments on each edge where hazard_detected = 1 and freeze = 0. It saturates at all-ones and does not wrap.
- Reset asserted mid-operation clears all pending entries immediately; no stall persists after rst rises.
- Elaboration check: error if 2**CNT_W - 1 < max(NOFWD_LAT, LOAD_LAT).

Test Plan:
- Reset, then issue_valid = 1, src1 = 3, no writes pending -> hazard_detected = 0, pending_mask = 0, stall_count = 0.
- fwd_en = 0: issue write r2, then a reader of r2 on the next cycle -> hazard 1 for exactly 2 cycles, reader accepted in the 3rd; stall_count = 2; pending_mask bit 2 reads 1, 1, 0.
- fwd_en = 1: ALU write r4 then reader of r4 -> no stall. Load r4 then reader (src2 = 4, has_two_src = 1) -> 1-cycle stall. Same reader with has_two_src = 0 -> no stall.
- Load r5 then reader with freeze held 3 cycles -> cnt[5] stays 1 and hazard stays 1 throughout, stall_count unchanged. After freeze drops: 1 stall, then accept.
- flush = 1 on a write-r6 instruction -> pending_mask bit 6 stays 0, hazard 0. Separately, drive stall_count to 0xFFFF via forced stalls -> stays 0xFFFF on further stalls.
- Write r7 (fwd_en = 0), assert rst low one cycle later -> pending_mask = 0 immediately; reader of r7 after rst rises sees no hazard.
